// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback stage.
// Opcodes, FSM encoding and flag bit positions.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_WB   = 2'b10
  } state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: add/sub/and/or with {N,Z,C} flags.
// C is always the carry-out of A+B, whatever the opcode.
module alu
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [1:0]   opcode,
  input  logic [W-1:0] operand_A,
  input  logic [W-1:0] operand_B,
  output logic [W-1:0] alu_result,
  output logic [2:0]   alu_flags
);

  logic [W:0] w_sum;

  assign w_sum = {1'b0, operand_A} + {1'b0, operand_B};

  always_comb begin
    alu_result = '0;
    unique case (opcode)
      OP_ADD: alu_result = w_sum[W-1:0];
      OP_SUB: alu_result = operand_A - operand_B;
      OP_AND: alu_result = operand_A & operand_B;
      OP_OR:  alu_result = operand_A | operand_B;
    endcase
  end

  always_comb begin
    alu_flags         = '0;
    alu_flags[FLAG_N] = alu_result[W-1];
    alu_flags[FLAG_Z] = ~|alu_result;
    alu_flags[FLAG_C] = w_sum[W];
  end

endmodule

// File: rtl/alu_regfile.sv
// 2**RA x W register file: two async reads, one sync write.
// Async active-low reset clears every entry.
module alu_regfile #(
  parameter int W  = 32,
  parameter int RA = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [RA-1:0] i_raddr_a,
  input  logic [RA-1:0] i_raddr_b,
  output logic [W-1:0]  o_rdata_a,
  output logic [W-1:0]  o_rdata_b,
  input  logic          i_we,
  input  logic [RA-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata
);

  logic [W-1:0] r_mem [2**RA];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**RA; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/alu_issue_wb.sv
// Non-pipelined issue/execute/writeback stage around the ALU.
// One instruction in flight; IDLE -> EXEC -> WB.
module alu_issue_wb
  import alu_pkg::*;
#(
  parameter int W  = 32,
  parameter int RA = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [1:0]    instr_opcode,
  input  logic [RA-1:0] instr_rd,
  input  logic [RA-1:0] instr_rsa,
  input  logic [RA-1:0] instr_rsb,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [RA-1:0] ld_addr,
  input  logic [W-1:0]  ld_data,
  output logic          res_valid,
  output logic [W-1:0]  res_data,
  output logic [RA-1:0] res_rd,
  output logic [2:0]    flags_q
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_opcode;
  logic [RA-1:0] r_rd;
  logic [RA-1:0] r_res_rd;
  logic [W-1:0]  r_opa;
  logic [W-1:0]  r_opb;
  logic [W-1:0]  r_res;
  logic [2:0]    r_flg;
  logic [2:0]    r_flags;

  logic          w_instr_rdy;
  logic          w_ld_rdy;
  logic          w_res_vld;
  logic          w_accept;
  logic          w_ld_acc;
  logic          w_in_wb;
  logic [W-1:0]  w_rda;
  logic [W-1:0]  w_rdb;
  logic [W-1:0]  w_alu_res;
  logic [2:0]    w_alu_flg;
  logic          w_we;
  logic [RA-1:0] w_waddr;
  logic [W-1:0]  w_wdata;

  // Readies are gated by rst_n so they stay low while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    w_instr_rdy = 1'b0;
    w_ld_rdy    = 1'b0;
    w_res_vld   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_instr_rdy = rst_n;
        w_ld_rdy    = rst_n;
        if (instr_valid && rst_n) begin
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        w_ld_rdy    = rst_n;
        w_state_nxt = S_WB;
      end
      S_WB: begin
        w_res_vld   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_accept = instr_valid & w_instr_rdy;
  assign w_ld_acc = ld_valid & w_ld_rdy;
  assign w_in_wb  = (r_state == S_WB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_opcode <= '0;
      r_rd     <= '0;
      r_res_rd <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_res    <= '0;
      r_flg    <= '0;
      r_flags  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_opcode <= instr_opcode;
        r_rd     <= instr_rd;
        r_opa    <= w_rda;
        r_opb    <= w_rdb;
      end
      if (r_state == S_EXEC) begin
        r_res    <= w_alu_res;
        r_flg    <= w_alu_flg;
        r_res_rd <= r_rd;
      end
      if (w_in_wb) begin
        r_flags <= r_flg;
      end
    end
  end

  // Writeback owns the single write port in WB; loads are refused then.
  assign w_we    = w_in_wb | w_ld_acc;
  assign w_waddr = w_in_wb ? r_rd  : ld_addr;
  assign w_wdata = w_in_wb ? r_res : ld_data;

  alu_regfile #(
    .W  (W),
    .RA (RA)
  ) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_raddr_a (instr_rsa),
    .i_raddr_b (instr_rsb),
    .o_rdata_a (w_rda),
    .o_rdata_b (w_rdb),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata)
  );

  alu #(
    .W (W)
  ) u_alu (
    .opcode     (r_opcode),
    .operand_A  (r_opa),
    .operand_B  (r_opb),
    .alu_result (w_alu_res),
    .alu_flags  (w_alu_flg)
  );

  assign instr_ready = w_instr_rdy;
  assign ld_ready    = w_ld_rdy;
  assign res_valid   = w_res_vld;
  assign res_data    = r_res;
  assign res_rd      = r_res_rd;
  assign flags_q     = r_flags;

endmodule

// File: tb/tb_alu_issue_wb.sv
// Directed bench for alu_issue_wb.
// Inputs driven 1ns after rising edges; outputs sampled there too.
module tb_alu_issue_wb;
  import alu_pkg::*;

  localparam int W  = 32;
  localparam int RA = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [1:0]    instr_opcode = '0;
  logic [RA-1:0] instr_rd = '0;
  logic [RA-1:0] instr_rsa = '0;
  logic [RA-1:0] instr_rsb = '0;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [RA-1:0] ld_addr = '0;
  logic [W-1:0]  ld_data = '0;
  logic          res_valid;
  logic [W-1:0]  res_data;
  logic [RA-1:0] res_rd;
  logic [2:0]    flags_q;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_n = 0;
  int acc_last = 0;
  int acc_gap = 0;
  int res_n = 0;
  int n0;
  int rn0;
  logic [2:0] prev_f = 3'b000;

  alu_issue_wb #(.W(W), .RA(RA)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_opcode (instr_opcode),
    .instr_rd     (instr_rd),
    .instr_rsa    (instr_rsa),
    .instr_rsb    (instr_rsb),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .res_rd       (res_rd),
    .flags_q      (flags_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && instr_valid && instr_ready) begin
      acc_n    <= acc_n + 1;
      acc_gap  <= cyc - acc_last;
      acc_last <= cyc;
    end
    if (res_valid) res_n <= res_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [2:0] a, input logic [31:0] d);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    chk("ld_ready", 32'(ld_ready), 32'd1);
    @(posedge clk); #1;
    ld_valid = 1'b0;
  endtask

  // ld_at: 0 none, 1 with accept, 2 during EXEC, 3 during WB
  task automatic issue(input string tag, input logic [1:0] op,
                       input logic [2:0] rd, input logic [2:0] a,
                       input logic [2:0] b, input logic [31:0] exp_d,
                       input logic [2:0] exp_f, input int ld_at,
                       input logic [2:0] la, input logic [31:0] ldd);
    instr_opcode = op;
    instr_rd     = rd;
    instr_rsa    = a;
    instr_rsb    = b;
    instr_valid  = 1'b1;
    ld_addr      = la;
    ld_data      = ldd;
    ld_valid     = (ld_at == 1);
    chk({tag, ":idle_ir"}, 32'(instr_ready), 32'd1);
    if (ld_at == 1) chk({tag, ":idle_ldr"}, 32'(ld_ready), 32'd1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    ld_valid    = (ld_at == 2);
    chk({tag, ":exec_rv"}, 32'(res_valid), 32'd0);
    chk({tag, ":exec_ir"}, 32'(instr_ready), 32'd0);
    if (ld_at == 2) chk({tag, ":exec_ldr"}, 32'(ld_ready), 32'd1);
    @(posedge clk); #1;
    ld_valid = (ld_at == 3);
    chk({tag, ":wb_rv"}, 32'(res_valid), 32'd1);
    chk({tag, ":wb_data"}, res_data, exp_d);
    chk({tag, ":wb_rd"}, 32'(res_rd), 32'(rd));
    chk({tag, ":wb_flags"}, 32'(flags_q), 32'(prev_f));
    if (ld_at == 3) chk({tag, ":wb_ldr"}, 32'(ld_ready), 32'd0);
    @(posedge clk); #1;
    ld_valid = 1'b0;
    chk({tag, ":post_rv"}, 32'(res_valid), 32'd0);
    chk({tag, ":post_flags"}, 32'(flags_q), 32'(exp_f));
    chk({tag, ":post_hold"}, res_data, exp_d);
    chk({tag, ":post_ir"}, 32'(instr_ready), 32'd1);
    prev_f = exp_f;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ir", 32'(instr_ready), 32'd0);
    chk("rst_ldr", 32'(ld_ready), 32'd0);
    chk("rst_rv", 32'(res_valid), 32'd0);
    chk("rst_data", res_data, 32'd0);
    chk("rst_flags", 32'(flags_q), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_ir", 32'(instr_ready), 32'd1);
    chk("rel_ldr", 32'(ld_ready), 32'd1);
    @(posedge clk); #1;

    load(3'd1, 32'd5);
    load(3'd2, 32'd3);
    issue("add", OP_ADD, 3'd3, 3'd1, 3'd2, 32'd8, 3'b000, 0, 3'd0, 0);
    issue("rd3", OP_ADD, 3'd6, 3'd3, 3'd0, 32'd8, 3'b000, 0, 3'd0, 0);

    load(3'd1, 32'd3);
    load(3'd2, 32'd5);
    issue("sub", OP_SUB, 3'd4, 3'd1, 3'd2, 32'hFFFF_FFFE, 3'b100,
          0, 3'd0, 0);

    load(3'd1, 32'hFFFF_FFFF);
    load(3'd2, 32'd1);
    issue("addc", OP_ADD, 3'd3, 3'd1, 3'd2, 32'd0, 3'b011, 0, 3'd0, 0);
    issue("or", OP_OR, 3'd3, 3'd1, 3'd2, 32'hFFFF_FFFF, 3'b101,
          0, 3'd0, 0);
    issue("and", OP_AND, 3'd4, 3'd1, 3'd2, 32'd1, 3'b001, 0, 3'd0, 0);

    load(3'd5, 32'h55);
    issue("wbld", OP_ADD, 3'd6, 3'd0, 3'd0, 32'd0, 3'b010,
          3, 3'd5, 32'hAA);
    issue("sameld", OP_ADD, 3'd6, 3'd5, 3'd0, 32'h55, 3'b000,
          1, 3'd5, 32'h77);
    issue("newr5", OP_ADD, 3'd7, 3'd5, 3'd0, 32'h77, 3'b000, 0, 3'd0, 0);
    issue("exld", OP_ADD, 3'd6, 3'd5, 3'd5, 32'hEE, 3'b000,
          2, 3'd6, 32'h12);
    issue("r6wb", OP_ADD, 3'd7, 3'd6, 3'd0, 32'hEE, 3'b000, 0, 3'd0, 0);

    // back-to-back: r2 = 1 + 1, then r7 = r2 + r2
    instr_opcode = OP_ADD;
    instr_rd     = 3'd2;
    instr_rsa    = 3'd2;
    instr_rsb    = 3'd4;
    instr_valid  = 1'b1;
    n0 = acc_n;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (acc_n != n0) break;
    end
    chk("b2b_acc1", 32'(acc_n), 32'(n0 + 1));
    instr_rd  = 3'd7;
    instr_rsa = 3'd2;
    instr_rsb = 3'd2;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (acc_n != n0 + 1) break;
    end
    instr_valid = 1'b0;
    chk("b2b_acc2", 32'(acc_n), 32'(n0 + 2));
    chk("b2b_gap", 32'(acc_gap), 32'd3);
    @(posedge clk); #1;
    chk("b2b_rv", 32'(res_valid), 32'd1);
    chk("b2b_data", res_data, 32'd4);
    chk("b2b_rd", 32'(res_rd), 32'd7);
    @(posedge clk); #1;
    prev_f = 3'b000;

    // reset asserted while the instruction is in EXEC
    instr_opcode = OP_OR;
    instr_rd     = 3'd1;
    instr_rsa    = 3'd4;
    instr_rsb    = 3'd4;
    instr_valid  = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    rn0 = res_n;
    rst_n = 1'b0;
    #1;
    chk("mrst_ir", 32'(instr_ready), 32'd0);
    chk("mrst_ldr", 32'(ld_ready), 32'd0);
    chk("mrst_flags", 32'(flags_q), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("mrst_rvcnt", 32'(res_n), 32'(rn0));
    chk("mrst_ir2", 32'(instr_ready), 32'd0);
    chk("mrst_data", res_data, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("mrel_ir", 32'(instr_ready), 32'd1);
    chk("mrel_flags", 32'(flags_q), 32'd0);
    chk("mrel_rd", 32'(res_rd), 32'd0);
    prev_f = 3'b000;
    for (int i = 0; i < 8; i++) begin
      issue("zero", OP_ADD, 3'(i), 3'(i), 3'(i), 32'd0, 3'b010,
            0, 3'd0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
